// File: rtl/coupling_pkg.sv
// Shared definitions for the coupling gain applier: coupling-mode encodings,
// Q14 gain constants and the slew-state encoding.
package coupling_pkg;

    localparam logic [1:0] MODE_MODULATORY = 2'b00;
    localparam logic [1:0] MODE_TRANSITION = 2'b01;
    localparam logic [1:0] MODE_HARMONIC   = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL    = 2'b11;

    localparam int GAIN_FULL = 16384;
    localparam int GAIN_HALF = 8192;
    localparam int GAIN_WEAK = 2048;

    typedef enum logic [1:0] {
        ST_SETTLED  = 2'd0,
        ST_SLEWING  = 2'd1,
        ST_SETTLING = 2'd2
    } slew_state_t;

endpackage

// File: rtl/coupling_gain_applier_if.sv
// Bus between the coupling-mode controller side and the gain applier.
// With COUPLING_SLEW_STATS_EN defined the bus also carries slew_ticks.
interface coupling_gain_applier_if #(
    parameter int WIDTH = 18
);
    logic                    clk_en;
    logic [1:0]              coupling_mode;
    logic signed [WIDTH-1:0] pac_gain_tgt;
    logic signed [WIDTH-1:0] harmonic_gain_tgt;
    logic signed [WIDTH-1:0] pac_drive;
    logic signed [WIDTH-1:0] harmonic_drive;
    logic signed [WIDTH-1:0] coupling_out;
    logic                    out_valid;
    logic signed [WIDTH-1:0] pac_gain_eff;
    logic signed [WIDTH-1:0] harmonic_gain_eff;
    logic                    gains_settled;
    logic                    mode_illegal;

`ifdef COUPLING_SLEW_STATS_EN
    logic [15:0]             slew_ticks;

    modport master (
        output clk_en, coupling_mode, pac_gain_tgt, harmonic_gain_tgt,
               pac_drive, harmonic_drive,
        input  coupling_out, out_valid, pac_gain_eff, harmonic_gain_eff,
               gains_settled, mode_illegal, slew_ticks
    );

    modport slave (
        input  clk_en, coupling_mode, pac_gain_tgt, harmonic_gain_tgt,
               pac_drive, harmonic_drive,
        output coupling_out, out_valid, pac_gain_eff, harmonic_gain_eff,
               gains_settled, mode_illegal, slew_ticks
    );
`else
    modport master (
        output clk_en, coupling_mode, pac_gain_tgt, harmonic_gain_tgt,
               pac_drive, harmonic_drive,
        input  coupling_out, out_valid, pac_gain_eff, harmonic_gain_eff,
               gains_settled, mode_illegal
    );

    modport slave (
        input  clk_en, coupling_mode, pac_gain_tgt, harmonic_gain_tgt,
               pac_drive, harmonic_drive,
        output coupling_out, out_valid, pac_gain_eff, harmonic_gain_eff,
               gains_settled, mode_illegal
    );
`endif

endinterface

// File: rtl/coupling_gain_slew.sv
// Single-gain conditioner: clamps the commanded target to [0, GAIN_MAX],
// substitutes FORCE_VAL when the mode is illegal, and steps the effective
// gain toward the target by at most SLEW_STEP per update tick.
module coupling_gain_slew
    import coupling_pkg::*;
#(
    parameter int WIDTH     = 18,
    parameter int SLEW_STEP = 8,
    parameter int GAIN_MAX  = GAIN_FULL,
    parameter int RESET_VAL = GAIN_FULL,
    parameter int FORCE_VAL = GAIN_FULL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clk_en,
    input  logic                    i_force,
    input  logic signed [WIDTH-1:0] i_tgt,
    output logic signed [WIDTH-1:0] o_tgt,
    output logic signed [WIDTH-1:0] o_eff,
    output logic signed [WIDTH-1:0] o_eff_next
);

    localparam logic signed [WIDTH-1:0] L_MAX    = WIDTH'(GAIN_MAX);
    localparam logic signed [WIDTH-1:0] L_RST    = WIDTH'(RESET_VAL);
    localparam logic signed [WIDTH-1:0] L_FORCE  = WIDTH'(FORCE_VAL);
    localparam logic signed [WIDTH-1:0] L_STEP   = WIDTH'(SLEW_STEP);
    localparam logic signed [WIDTH:0]   L_STEP_P = (WIDTH+1)'(SLEW_STEP);
    localparam logic signed [WIDTH:0]   L_STEP_N = (WIDTH+1)'(-SLEW_STEP);

    logic signed [WIDTH-1:0] r_eff;
    logic signed [WIDTH-1:0] w_tgt;
    logic signed [WIDTH:0]   w_diff;
    logic signed [WIDTH-1:0] w_eff_next;

    // Target conditioning and step-limited next value.
    always_comb begin
        w_tgt = i_tgt;
        if (i_force) begin
            w_tgt = L_FORCE;
        end else if (i_tgt[WIDTH-1]) begin
            w_tgt = '0;
        end else if (i_tgt > L_MAX) begin
            w_tgt = L_MAX;
        end

        // One guard bit: both operands are bounded, so this cannot wrap.
        w_diff = {w_tgt[WIDTH-1], w_tgt} - {r_eff[WIDTH-1], r_eff};

        w_eff_next = r_eff;
        if ((w_diff <= L_STEP_P) && (w_diff >= L_STEP_N)) begin
            w_eff_next = w_tgt;
        end else if (w_diff > L_STEP_P) begin
            w_eff_next = r_eff + L_STEP;
        end else begin
            w_eff_next = r_eff - L_STEP;
        end
    end

    // Effective gain register, advanced only on the update tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eff <= L_RST;
        end else if (i_clk_en) begin
            r_eff <= w_eff_next;
        end
    end

    assign o_tgt      = w_tgt;
    assign o_eff      = r_eff;
    assign o_eff_next = w_eff_next;

endmodule

// File: rtl/coupling_gain_applier.sv
// Slews the PAC and harmonic coupling gains, applies them to their drive
// signals and sums the result into one saturated coupling drive.
// Optional feature macro: COUPLING_SLEW_STATS_EN (adds slew_ticks on the bus).
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_SETTLED  | gains equal targets and have held for SETTLE_TICKS ticks
// ST_SLEWING  | at least one gain is still stepping toward its target
// ST_SETTLING | both gains at target, counting stable ticks
module coupling_gain_applier
    import coupling_pkg::*;
#(
    parameter int WIDTH        = 18,
    parameter int FRAC         = 14,
    parameter int SLEW_STEP    = 8,
    parameter int SETTLE_TICKS = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    coupling_gain_applier_if.slave   bus
);

    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = ($clog2(SETTLE_TICKS) > 0) ? $clog2(SETTLE_TICKS) : 1;
    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(SETTLE_TICKS - 1);
    localparam logic signed [W2:0] L_SAT_MAX = (W2+1)'((2 ** (WIDTH-1)) - 1);
    localparam logic signed [W2:0] L_SAT_MIN = (W2+1)'(-(2 ** (WIDTH-1)));

    logic                    w_illegal;
    logic signed [WIDTH-1:0] w_pac_tgt,  w_pac_eff,  w_pac_next;
    logic signed [WIDTH-1:0] w_harm_tgt, w_harm_eff, w_harm_next;
    logic                    w_tgt_moved;
    logic                    w_next_at_tgt;
    logic signed [W2:0]      w_sum;
    logic signed [W2:0]      w_shift;
    logic signed [WIDTH-1:0] w_sat;

    slew_state_t             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_settled;
    logic                    r_illegal;
    logic signed [W2-1:0]    r_prod_pac;
    logic signed [W2-1:0]    r_prod_harm;
    logic                    r_v1;
    logic signed [WIDTH-1:0] r_out;
    logic                    r_out_valid;

    assign w_illegal = (bus.coupling_mode == MODE_ILLEGAL);

    coupling_gain_slew #(
        .WIDTH     (WIDTH),
        .SLEW_STEP (SLEW_STEP),
        .GAIN_MAX  (GAIN_FULL),
        .RESET_VAL (GAIN_FULL),
        .FORCE_VAL (GAIN_FULL)
    ) u_pac_slew (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clk_en   (bus.clk_en),
        .i_force    (w_illegal),
        .i_tgt      (bus.pac_gain_tgt),
        .o_tgt      (w_pac_tgt),
        .o_eff      (w_pac_eff),
        .o_eff_next (w_pac_next)
    );

    coupling_gain_slew #(
        .WIDTH     (WIDTH),
        .SLEW_STEP (SLEW_STEP),
        .GAIN_MAX  (GAIN_FULL),
        .RESET_VAL (GAIN_WEAK),
        .FORCE_VAL (GAIN_WEAK)
    ) u_harm_slew (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clk_en   (bus.clk_en),
        .i_force    (w_illegal),
        .i_tgt      (bus.harmonic_gain_tgt),
        .o_tgt      (w_harm_tgt),
        .o_eff      (w_harm_eff),
        .o_eff_next (w_harm_next)
    );

    // Target-vs-gain comparisons feeding the state machine, plus the
    // stage-2 sum, rescale and saturation.
    always_comb begin
        w_tgt_moved   = (w_pac_tgt != w_pac_eff) || (w_harm_tgt != w_harm_eff);
        w_next_at_tgt = (w_pac_next == w_pac_tgt) && (w_harm_next == w_harm_tgt);

        w_sum   = (W2+1)'(r_prod_pac) + (W2+1)'(r_prod_harm);
        w_shift = w_sum >>> FRAC;
        if (w_shift > L_SAT_MAX) begin
            w_sat = L_SAT_MAX[WIDTH-1:0];
        end else if (w_shift < L_SAT_MIN) begin
            w_sat = L_SAT_MIN[WIDTH-1:0];
        end else begin
            w_sat = w_shift[WIDTH-1:0];
        end
    end

    // Settle-tracking state machine with registered gains_settled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_SETTLED;
            r_cnt     <= '0;
            r_settled <= 1'b1;
        end else if (bus.clk_en) begin
            case (r_state)
                ST_SETTLED: begin
                    if (w_tgt_moved) begin
                        r_state   <= ST_SLEWING;
                        r_settled <= 1'b0;
                    end
                end
                ST_SLEWING: begin
                    if (w_next_at_tgt) begin
                        r_state <= ST_SETTLING;
                        r_cnt   <= '0;
                    end
                end
                ST_SETTLING: begin
                    if (w_tgt_moved) begin
                        r_state <= ST_SLEWING;
                    end else if (r_cnt == L_CNT_LAST) begin
                        r_state   <= ST_SETTLED;
                        r_settled <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= ST_SETTLED;
                    r_settled <= 1'b1;
                end
            endcase
        end
    end

    // Sticky illegal-mode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else if (bus.clk_en && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

    // Two-stage multiply/sum pipeline; products use the pre-update gains.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prod_pac  <= '0;
            r_prod_harm <= '0;
            r_v1        <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.clk_en && r_v1;
            if (bus.clk_en) begin
                r_prod_pac  <= W2'(bus.pac_drive) * W2'(w_pac_eff);
                r_prod_harm <= W2'(bus.harmonic_drive) * W2'(w_harm_eff);
                r_v1        <= 1'b1;
                r_out       <= w_sat;
            end
        end
    end

`ifdef COUPLING_SLEW_STATS_EN
    logic [15:0] r_slew_ticks;

    // Ticks spent slewing since the last departure from SETTLED, saturating.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slew_ticks <= '0;
        end else if (bus.clk_en) begin
            if ((r_state == ST_SETTLED) && w_tgt_moved) begin
                r_slew_ticks <= '0;
            end else if ((r_state == ST_SLEWING) && (r_slew_ticks != 16'hFFFF)) begin
                r_slew_ticks <= r_slew_ticks + 16'd1;
            end
        end
    end

    assign bus.slew_ticks = r_slew_ticks;
`endif

    assign bus.coupling_out      = r_out;
    assign bus.out_valid         = r_out_valid;
    assign bus.pac_gain_eff      = w_pac_eff;
    assign bus.harmonic_gain_eff = w_harm_eff;
    assign bus.gains_settled     = r_settled;
    assign bus.mode_illegal      = r_illegal;

endmodule

// File: tb/tb_coupling_gain_applier.sv
// Directed bench for coupling_gain_applier: table of datapath vectors at
// fixed gains plus hand-written slew, settle, illegal-mode and reset sequences.
module tb_coupling_gain_applier;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    coupling_gain_applier_if #(.WIDTH(18)) bus ();

    coupling_gain_applier #(
        .WIDTH        (18),
        .FRAC         (14),
        .SLEW_STEP    (8),
        .SETTLE_TICKS (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [1:0] mode;
        int         pac_tgt;
        int         harm_tgt;
        int         pac_drv;
        int         harm_drv;
        int         exp_out;
    } vec_t;

    vec_t tbl [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d vectors, required completion", n_vec);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [1:0] mode, input int pt, input int ht,
                          input int pd, input int hd);
        bus.coupling_mode     = mode;
        bus.pac_gain_tgt      = 18'(pt);
        bus.harmonic_gain_tgt = 18'(ht);
        bus.pac_drive         = 18'(pd);
        bus.harmonic_drive    = 18'(hd);
    endtask

    task automatic tick();
        @(negedge clk);
        bus.clk_en = 1'b1;
        @(posedge clk);
        #1;
        bus.clk_en = 1'b0;
    endtask

    task automatic idle_clk();
        @(negedge clk);
        bus.clk_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic longint pac_eff();
        return longint'(bus.pac_gain_eff);
    endfunction

    function automatic longint harm_eff();
        return longint'(bus.harmonic_gain_eff);
    endfunction

    function automatic longint cout();
        return longint'(bus.coupling_out);
    endfunction

    initial begin
        int prev_exp;
        int t_pac;
        int t_harm;
        int t_set;

        n_vec  = 0;
        n_miss = 0;

        // Gains held at 16384 / 2048 for every table entry: out = pac + harm/8 (floor).
        tbl[0] = '{2'b00, 16384, 2048,   8192,  16384,  10240};
        tbl[1] = '{2'b01, 16384, 2048,      0,      0,      0};
        tbl[2] = '{2'b10, 20000, 2048,  -1000,    800,   -900};
        tbl[3] = '{2'b00, 16385, 2048,    100,     -3,     99};
        tbl[4] = '{2'b01, 131071, 2048, 131071, 131071, 131071};
        tbl[5] = '{2'b10, 16384, 2048, -131072, -131072, -131072};
        tbl[6] = '{2'b00, 16384, 2048, 120000,  90000, 131071};
        tbl[7] = '{2'b00, 16384, 2048, 120000,  80000, 130000};
        tbl[8] = '{2'b01, 16384, 2048,     -5,      0,     -5};
        tbl[9] = '{2'b10, 16384, 2048,      0,     -1,     -1};

        rst_n      = 1'b0;
        bus.clk_en = 1'b0;
        set_in(2'b00, 16384, 2048, 8192, 16384);
        repeat (3) @(posedge clk);
        #1;
        check("rst_pac_eff",  pac_eff(), 16384);
        check("rst_harm_eff", harm_eff(), 2048);
        check("rst_out",      cout(), 0);
        check("rst_valid",    bus.out_valid, 0);
        check("rst_settled",  bus.gains_settled, 1);
        check("rst_illegal",  bus.mode_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hold reset gains for 20 ticks; output appears from tick 2.
        for (int t = 1; t <= 20; t++) begin
            tick();
            check("hold_pac_eff",  pac_eff(), 16384);
            check("hold_harm_eff", harm_eff(), 2048);
            check("hold_settled",  bus.gains_settled, 1);
            check("hold_valid",    bus.out_valid, (t >= 2) ? 1 : 0);
            check("hold_out",      cout(), (t >= 2) ? 10240 : 0);
        end

        idle_clk();
        check("idle_valid", bus.out_valid, 0);
        check("idle_out",   cout(), 10240);
        set_in(2'b00, 16384, 2048, 0, 0);
        idle_clk();
        check("idle_pac_eff", pac_eff(), 16384);
        check("idle_out2",    cout(), 10240);

        prev_exp = 10240;
        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].mode, tbl[i].pac_tgt, tbl[i].harm_tgt,
                   tbl[i].pac_drv, tbl[i].harm_drv);
            tick();
            check("tbl_latency", cout(), prev_exp);
            check("tbl_valid",   bus.out_valid, 1);
            tick();
            check("tbl_out",      cout(), tbl[i].exp_out);
            check("tbl_pac_eff",  pac_eff(), 16384);
            check("tbl_harm_eff", harm_eff(), 2048);
            check("tbl_settled",  bus.gains_settled, 1);
            prev_exp = tbl[i].exp_out;
        end

        // Illegal mode forces reset gains regardless of 0 / 0 targets.
        set_in(2'b11, 0, 0, 0, 0);
        for (int t = 1; t <= 5; t++) begin
            tick();
            check("ill_flag",     bus.mode_illegal, 1);
            check("ill_pac_eff",  pac_eff(), 16384);
            check("ill_harm_eff", harm_eff(), 2048);
            check("ill_settled",  bus.gains_settled, 1);
        end
        set_in(2'b00, 16384, 2048, 0, 0);
        tick();
        check("ill_sticky", bus.mode_illegal, 1);

        // Step to 8192 / 8192.
        set_in(2'b10, 8192, 8192, 0, 0);
        t_pac = -1; t_harm = -1; t_set = -1;
        for (int t = 1; t <= 1200 && t_set < 0; t++) begin
            tick();
            if (t == 1) begin
                check("slew_first_pac",  pac_eff(), 16376);
                check("slew_first_harm", harm_eff(), 2056);
                check("slew_unsettled",  bus.gains_settled, 0);
            end
            if (t_pac < 0 && pac_eff() == 8192) t_pac = t;
            if (t_harm < 0 && harm_eff() == 8192) t_harm = t;
            if (t_set < 0 && t > 1 && bus.gains_settled) t_set = t;
        end
        check("slew_pac_ticks",    t_pac, 1024);
        check("slew_harm_ticks",   t_harm, 768);
        check("slew_settle_ticks", t_set, 1040);

        // Step to 16384 / 16384, then saturation.
        set_in(2'b01, 16384, 16384, 0, 0);
        t_set = -1;
        for (int t = 1; t <= 1200 && t_set < 0; t++) begin
            tick();
            if (t > 1 && bus.gains_settled) t_set = t;
        end
        check("full_settle_ticks", t_set, 1040);
        check("full_pac_eff",  pac_eff(), 16384);
        check("full_harm_eff", harm_eff(), 16384);
        set_in(2'b01, 16384, 16384, 131071, 131071);
        tick();
        tick();
        check("sat_pos", cout(), 131071);
        set_in(2'b01, 16384, 16384, -131072, -131072);
        tick();
        check("sat_latency", cout(), 131071);
        tick();
        check("sat_neg", cout(), -131072);

        // Negative harmonic target clamps to 0.
        set_in(2'b10, 16384, -3000, 1000, 1000);
        t_set = -1;
        for (int t = 1; t <= 2100 && t_set < 0; t++) begin
            tick();
            if (t > 1 && bus.gains_settled) t_set = t;
        end
        check("clamp_settle_ticks", t_set, 2064);
        check("clamp_harm_eff", harm_eff(), 0);
        check("clamp_pac_eff",  pac_eff(), 16384);
        tick();
        check("clamp_out", cout(), 1000);

        // Reset in the middle of a PAC slew.
        set_in(2'b10, -3000, -3000, 1000, 1000);
        for (int t = 1; t <= 548; t++) tick();
        check("mid_pac_eff",  pac_eff(), 12000);
        check("mid_harm_eff", harm_eff(), 0);
        check("mid_settled",  bus.gains_settled, 0);
        check("mid_valid",    bus.out_valid, 1);
        @(negedge clk);
        rst_n      = 1'b0;
        bus.clk_en = 1'b1;
        @(posedge clk);
        #1;
        bus.clk_en = 1'b0;
        check("mrst_pac_eff",  pac_eff(), 16384);
        check("mrst_harm_eff", harm_eff(), 2048);
        check("mrst_out",      cout(), 0);
        check("mrst_valid",    bus.out_valid, 0);
        check("mrst_settled",  bus.gains_settled, 1);
        check("mrst_illegal",  bus.mode_illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_valid",    bus.out_valid, 0);
        check("post_pac_eff",  pac_eff(), 16376);
        check("post_harm_eff", harm_eff(), 2040);
        check("post_settled",  bus.gains_settled, 0);
        tick();
        check("post_valid2",   bus.out_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
